div_16by8_seq: RTL and testbench

Sequential restoring divider: 16-bit unsigned dividend by 8-bit unsigned divisor, producing an 8-bit quotient and an 8-bit remainder. It is the inverse companion to the 8x8 approximate multiplier datapath, used to recover operands and check products in the same arithmetic test fabric. It computes one quotient bit per clock, with valid/ready handshakes on both the input and output sides. Results are exact; error cases (divide-by-zero, quotient overflow) are flagged rather than computed.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 21 ++
 rtl/div_16by8_seq.sv | 160 ++++++++++++++++
 tb/tb_div_16by8_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared widths, state encoding and constants for the sequential 16/8 divider.
package div_pkg;

  localparam int unsigned DIVIDEND_W = 16;
  localparam int unsigned DIVISOR_W  = 8;
  localparam int unsigned QUOT_W     = 8;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned P_W        = DIVISOR_W + 1;

  localparam logic [QUOT_W-1:0] QUOT_SAT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
(
  input  logic [P_W-1:0]       p_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [P_W-1:0]       p_o,
  output logic                 q_bit_o
);

  // p_i[P_W-1] is zero by invariant; carrying it keeps the arithmetic width-exact.
  logic [P_W:0] t_ext;

  always_comb begin
    t_ext   = {p_i, bit_i};
    q_bit_o = (t_ext >= (P_W + 1)'(divisor_i));
    p_o     = q_bit_o ? P_W'(t_ext - (P_W + 1)'(divisor_i)) : P_W'(t_ext);
  end

endmodule

// File: rtl/div_16by8_seq.sv
// Sequential restoring 16/8 unsigned divider, one quotient bit per clock, valid/ready on both sides.
// Optional remainder output enabled by defining DIV_REM_EN.
module div_16by8_seq
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  div_state_e            state_q, state_d;
  logic [P_W-1:0]        p_q, p_d;
  logic [QUOT_W-1:0]     q_q, q_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [QUOT_W-1:0]     quot_q, quot_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  dbz_q, dbz_d;
  logic                  ovf_q, ovf_d;
  logic [DIVISOR_W-1:0]  rem_d;

  logic [P_W-1:0]        step_p;
  logic                  step_bit;

  div_step u_step (
    .p_i       (p_q),
    .bit_i     (q_q[QUOT_W-1]),
    .divisor_i (dvs_q),
    .p_o       (step_p),
    .q_bit_o   (step_bit)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quot_d      = quot_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    rem_d       = remainder;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvs_d      = divisor;
          in_ready_d = 1'b0;
          if (divisor == '0) begin
            dbz_d       = 1'b1;
            quot_d      = QUOT_SAT;
            rem_d       = dividend[DIVISOR_W-1:0];
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else if (dividend[DIVIDEND_W-1:DIVISOR_W] >= divisor) begin
            ovf_d       = 1'b1;
            quot_d      = QUOT_SAT;
            rem_d       = '0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            p_d     = {1'b0, dividend[DIVIDEND_W-1:DIVISOR_W]};
            q_d     = dividend[QUOT_W-1:0];
            cnt_d   = CNT_W'(QUOT_W - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        p_d = step_p;
        q_d = {q_q[QUOT_W-2:0], step_bit};
        if (cnt_q == '0) begin
          quot_d      = {q_q[QUOT_W-2:0], step_bit};
          rem_d       = step_p[DIVISOR_W-1:0];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          dbz_d       = 1'b0;
          ovf_d       = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      p_q         <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quot_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      q_q         <= q_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quot_q      <= quot_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef DIV_REM_EN
  logic [DIVISOR_W-1:0] rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign remainder = rem_q;
`else
  // Remainder not built; rem_d is computed but intentionally has no sink.
  logic rem_unused;
  assign rem_unused = ^rem_d;
  assign remainder  = '0;
`endif

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quot_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_div_16by8_seq.sv
// Scoreboard bench for div_16by8_seq: directed operands, queued expectations, monitor on output handshake.
module tb_div_16by8_seq;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t mon_e;

  div_16by8_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rexp(input logic [7:0] r);
`ifdef DIV_REM_EN
    return r;
`else
    return 8'h00;
`endif
  endfunction

  function automatic exp_t mk(input logic [7:0] q, input logic [7:0] r,
                              input logic dbz, input logic ovf);
    exp_t e;
    e.q   = q;
    e.r   = rexp(r);
    e.dbz = dbz;
    e.ovf = ovf;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got q=%0d with empty scoreboard expected none at %0t",
                 quotient, $time);
      end else begin
        mon_e = sb.pop_front();
        check("quotient", int'(quotient), int'(mon_e.q));
        check("remainder", int'(remainder), int'(mon_e.r));
        check("div_by_zero", int'(div_by_zero), int'(mon_e.dbz));
        check("overflow", int'(overflow), int'(mon_e.ovf));
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_quotient"}, int'(quotient), 0);
    check({tag, "_remainder"}, int'(remainder), 0);
    check({tag, "_div_by_zero"}, int'(div_by_zero), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
  endtask

  task automatic send(input logic [15:0] dd, input logic [7:0] dv,
                      input logic push, input exp_t e);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst_low");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("rst_rel");

    // Normal, large-quotient, and both error paths.
    send(16'd1000, 8'd7, 1'b1, mk(8'd142, 8'd6, 1'b0, 1'b0));
    drain();
    send(16'hFEFF, 8'hFF, 1'b1, mk(8'hFF, 8'hFE, 1'b0, 1'b0));
    drain();
    send(16'h1234, 8'd0, 1'b1, mk(8'hFF, 8'h34, 1'b1, 1'b0));
    check("dbz_latency_out_valid", int'(out_valid), 1);
    drain();
    send(16'h0800, 8'd8, 1'b1, mk(8'hFF, 8'h00, 1'b0, 1'b1));
    check("ovf_latency_out_valid", int'(out_valid), 1);
    drain();

    // Backpressure: result must hold while out_ready is low; a new request is ignored.
    out_ready = 1'b0;
    send(16'd100, 8'd10, 1'b1, mk(8'd10, 8'd0, 1'b0, 1'b0));
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("bp_out_valid_seen", int'(out_valid), 1);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        in_valid = 1'b1;
        dividend = 16'd50;
        divisor  = 8'd5;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("bp_quotient", int'(quotient), 10);
      check("bp_remainder", int'(remainder), 0);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (12) @(posedge clk);
    #1;
    check("bp_no_extra_valid", int'(out_valid), 0);

    // Reset in the middle of CALC discards the operation.
    send(16'd1000, 8'd7, 1'b0, mk(8'd0, 8'd0, 1'b0, 1'b0));
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(16'd200, 8'd3, 1'b1, mk(8'd66, 8'd2, 1'b0, 1'b0));
    drain();
    repeat (12) @(posedge clk);
    #1;
    check("post_rst_idle", int'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
